// File: rtl/game_ctrl_fsm.sv
// rtl/game_ctrl_fsm.sv - N-player game-state controller with lives, respawn delay and resumable pause
//
// Ports:
//   clk           system clock, all state changes on posedge
//   reset         asynchronous active-low hard reset
//   soft_reset    synchronous restart request (level)
//   start, pause  button levels; only rising edges act
//   tick          frame tick enable for the respawn timer
//   dead          per-player death flags, sampled in PLAYING only
//   state_game    current state code (the state register itself)
//   lives         packed per-player life counters, player i at [i*LIVES_W +: LIVES_W]
//   alive         per-player lives != 0
//   respawn_left  remaining respawn ticks, 0 unless in (paused) RESPAWN
module game_ctrl_fsm #(
    parameter int NUM_PLAYERS   = 2,
    parameter int LIVES_W       = 3,
    parameter int INIT_LIVES    = 3,
    parameter int RESPAWN_TICKS = 60,
    parameter int TIMER_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           soft_reset,
    input  logic                           start,
    input  logic                           pause,
    input  logic                           tick,
    input  logic [NUM_PLAYERS-1:0]         dead,
    output logic [2:0]                     state_game,
    output logic [NUM_PLAYERS*LIVES_W-1:0] lives,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic [TIMER_W-1:0]             respawn_left
);

    typedef enum logic [2:0] {
        ST_START    = 3'b000,
        ST_PLAYING  = 3'b001,
        ST_PAUSE    = 3'b010,
        ST_RESET    = 3'b011,
        ST_GAMEOVER = 3'b100,
        ST_RESPAWN  = 3'b101
    } state_t;

    state_t                         state_q, state_d;
    state_t                         ret_q, ret_d;
    logic [NUM_PLAYERS*LIVES_W-1:0] lives_q, lives_d;
    logic [NUM_PLAYERS*LIVES_W-1:0] lives_hit;
    logic [TIMER_W-1:0]             timer_q, timer_d;
    logic                           start_q, pause_q;
    logic                           start_rise, pause_rise;
    logic [NUM_PLAYERS-1:0]         hit;

    assign start_rise   = start & ~start_q;
    assign pause_rise   = pause & ~pause_q;
    assign state_game   = state_q;
    assign lives        = lives_q;
    assign respawn_left = timer_q;

    always_comb begin
        alive = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            alive[i] = |lives_q[i*LIVES_W +: LIVES_W];
        end
    end

    // Only players with lives left can be hit, so the decrement never wraps.
    assign hit = dead & alive;

    always_comb begin
        lives_hit = lives_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            lives_hit[i*LIVES_W +: LIVES_W] = lives_q[i*LIVES_W +: LIVES_W] - LIVES_W'(hit[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        lives_d = lives_q;
        timer_d = timer_q;
        case (state_q)
            ST_RESET: begin
                lives_d = {NUM_PLAYERS{LIVES_W'(INIT_LIVES)}};
                timer_d = '0;
                state_d = ST_START;
            end
            ST_START: begin
                if (soft_reset) begin
                    state_d = ST_RESET;
                end else if (start_rise) begin
                    state_d = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (soft_reset) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end else if (hit != '0) begin
                    // A pause edge in the same cycle as a hit is intentionally dropped.
                    lives_d = lives_hit;
                    if (lives_hit == '0) begin
                        state_d = ST_GAMEOVER;
                    end else begin
                        state_d = ST_RESPAWN;
                        timer_d = TIMER_W'(RESPAWN_TICKS);
                    end
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                    ret_d   = ST_PLAYING;
                end
            end
            ST_RESPAWN: begin
                if (soft_reset) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                    ret_d   = ST_RESPAWN;
                end else if (tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                    if (timer_q == TIMER_W'(1)) begin
                        state_d = ST_PLAYING;
                    end
                end
            end
            ST_PAUSE: begin
                if (soft_reset) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end else if (start_rise || pause_rise) begin
                    state_d = ret_q;
                end
            end
            ST_GAMEOVER: begin
                if (soft_reset || start_rise) begin
                    state_d = ST_RESET;
                end
            end
            default: begin
                state_d = ST_RESET;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            ret_q   <= ST_PLAYING;
            lives_q <= {NUM_PLAYERS{LIVES_W'(INIT_LIVES)}};
            timer_q <= '0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            lives_q <= lives_d;
            timer_q <= timer_d;
            start_q <= start;
            pause_q <= pause;
        end
    end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb/tb_game_ctrl_fsm.sv - randomized and directed bench for game_ctrl_fsm against a behavioural model
module tb_game_ctrl_fsm;

    localparam int NP    = 2;
    localparam int LW    = 3;
    localparam int INIT  = 3;
    localparam int TICKS = 3;
    localparam int TW    = 8;

    localparam int C_START    = 0;
    localparam int C_PLAYING  = 1;
    localparam int C_PAUSE    = 2;
    localparam int C_RESET    = 3;
    localparam int C_GAMEOVER = 4;
    localparam int C_RESPAWN  = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             soft_reset = 1'b0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             tick = 1'b0;
    logic [NP-1:0]    dead = '0;
    logic [2:0]       state_game;
    logic [NP*LW-1:0] lives;
    logic [NP-1:0]    alive;
    logic [TW-1:0]    respawn_left;

    int checks = 0;
    int errors = 0;

    int m_state, m_ret, m_timer;
    int m_lives [NP];
    bit m_sq, m_pq;

    game_ctrl_fsm #(
        .NUM_PLAYERS(NP), .LIVES_W(LW), .INIT_LIVES(INIT),
        .RESPAWN_TICKS(TICKS), .TIMER_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .soft_reset(soft_reset), .start(start),
        .pause(pause), .tick(tick), .dead(dead), .state_game(state_game),
        .lives(lives), .alive(alive), .respawn_left(respawn_left)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lives();
        int v = 0;
        for (int i = 0; i < NP; i++) v += m_lives[i] * (1 << (i * LW));
        return v;
    endfunction

    function automatic int exp_alive();
        int v = 0;
        for (int i = 0; i < NP; i++) if (m_lives[i] > 0) v += (1 << i);
        return v;
    endfunction

    function automatic int total_lives();
        int s = 0;
        for (int i = 0; i < NP; i++) s += m_lives[i];
        return s;
    endfunction

    task automatic model_reset();
        m_state = C_RESET;
        m_ret   = C_PLAYING;
        m_timer = 0;
        m_sq    = 0;
        m_pq    = 0;
        for (int i = 0; i < NP; i++) m_lives[i] = INIT;
    endtask

    // Game rules applied once per clock edge from the inputs seen at that edge.
    task automatic model_update();
        bit sr, pr;
        int nhit;
        if (!reset) begin
            model_reset();
            return;
        end
        sr = start && !m_sq;
        pr = pause && !m_pq;
        m_sq = start;
        m_pq = pause;
        case (m_state)
            C_RESET: begin
                for (int i = 0; i < NP; i++) m_lives[i] = INIT;
                m_timer = 0;
                m_state = C_START;
            end
            C_START: begin
                if (soft_reset) m_state = C_RESET;
                else if (sr) m_state = C_PLAYING;
            end
            C_PLAYING: begin
                if (soft_reset) begin
                    m_state = C_RESET;
                    m_timer = 0;
                end else begin
                    nhit = 0;
                    for (int i = 0; i < NP; i++) begin
                        if (dead[i] && m_lives[i] > 0) begin
                            m_lives[i] = m_lives[i] - 1;
                            nhit++;
                        end
                    end
                    if (nhit > 0) begin
                        if (total_lives() == 0) m_state = C_GAMEOVER;
                        else begin
                            m_state = C_RESPAWN;
                            m_timer = TICKS;
                        end
                    end else if (pr) begin
                        m_state = C_PAUSE;
                        m_ret   = C_PLAYING;
                    end
                end
            end
            C_RESPAWN: begin
                if (soft_reset) begin
                    m_state = C_RESET;
                    m_timer = 0;
                end else if (pr) begin
                    m_state = C_PAUSE;
                    m_ret   = C_RESPAWN;
                end else if (tick) begin
                    m_timer = m_timer - 1;
                    if (m_timer == 0) m_state = C_PLAYING;
                end
            end
            C_PAUSE: begin
                if (soft_reset) begin
                    m_state = C_RESET;
                    m_timer = 0;
                end else if (sr || pr) m_state = m_ret;
            end
            C_GAMEOVER: begin
                if (soft_reset || sr) m_state = C_RESET;
            end
            default: m_state = C_RESET;
        endcase
    endtask

    task automatic model_check();
        cmp("state_game", int'(state_game), m_state);
        cmp("lives", int'(lives), exp_lives());
        cmp("alive", int'(alive), exp_alive());
        cmp("respawn_left", int'(respawn_left), m_timer);
    endtask

    // One clock: inputs already set; update the model at the edge, check on the falling edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
            model_check();
        end
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        step(n);
        tick = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        cmp("async_state", int'(state_game), C_RESET);
        cmp("async_respawn_left", int'(respawn_left), 0);
        cmp("async_lives", int'(lives), 27);
        @(negedge clk);
        model_update();
        model_check();
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        @(negedge clk);
        cmp("reset_state", int'(state_game), 3);
        cmp("reset_respawn_left", int'(respawn_left), 0);
        reset = 1'b1;

        // Reset then START, lives 3/3.
        step();
        cmp("lit_start_state", int'(state_game), 0);
        cmp("lit_start_lives", int'(lives), 27);
        cmp("lit_start_alive", int'(alive), 3);

        // Start edge, then held start does not re-trigger.
        start = 1'b1;
        step();
        cmp("lit_playing", int'(state_game), 1);
        step(10);
        cmp("lit_start_held", int'(state_game), 1);
        start = 1'b0;

        // Death of p0 -> RESPAWN, dead ignored while respawning.
        dead = 2'b01;
        step();
        cmp("lit_respawn_state", int'(state_game), 5);
        cmp("lit_respawn_lives", int'(lives), 26);
        cmp("lit_respawn_timer", int'(respawn_left), 3);
        run_ticks(1);
        cmp("lit_dead_ignored", int'(lives), 26);

        // Pause freezes the timer; a fresh pause edge resumes RESPAWN.
        pause = 1'b1;
        step();
        cmp("lit_pause_state", int'(state_game), 2);
        pause = 1'b0;
        run_ticks(5);
        cmp("lit_pause_timer", int'(respawn_left), 2);
        pause = 1'b1;
        step();
        cmp("lit_resume", int'(state_game), 5);
        pause = 1'b0;
        dead  = 2'b00;
        run_ticks(2);
        cmp("lit_back_playing", int'(state_game), 1);
        cmp("lit_back_timer", int'(respawn_left), 0);

        // Down to 1/1 then a simultaneous double death with a pause edge -> GAMEOVER.
        dead = 2'b11; step(); dead = 2'b00; run_ticks(3);
        dead = 2'b10; step(); dead = 2'b00; run_ticks(3);
        cmp("lit_one_one", int'(lives), 9);
        dead  = 2'b11;
        pause = 1'b1;
        step();
        cmp("lit_gameover", int'(state_game), 4);
        cmp("lit_gameover_lives", int'(lives), 0);
        cmp("lit_gameover_alive", int'(alive), 0);
        dead  = 2'b00;
        pause = 1'b0;
        start = 1'b1;
        step();
        cmp("lit_go_reset", int'(state_game), 3);
        step();
        cmp("lit_go_start", int'(state_game), 0);
        cmp("lit_go_lives", int'(lives), 27);

        // Kill p1 completely, then its dead flag is ignored.
        start = 1'b0; step();
        start = 1'b1; step();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            dead = 2'b10; step(); dead = 2'b00; run_ticks(3);
        end
        dead = 2'b10;
        step(5);
        cmp("lit_p1_out_state", int'(state_game), 1);
        cmp("lit_p1_out_lives", int'(lives), 3);
        cmp("lit_p1_out_alive", int'(alive), 1);
        dead  = 2'b00;
        pause = 1'b1; step(); pause = 1'b0;
        soft_reset = 1'b1;
        step();
        cmp("lit_soft_reset", int'(state_game), 3);
        soft_reset = 1'b0;
        step();

        // Asynchronous reset in the middle of a respawn.
        start = 1'b1; step(); start = 1'b0;
        dead = 2'b01; step(); dead = 2'b00;
        cmp("lit_pre_async", int'(state_game), 5);
        async_reset();

        // Randomized play.
        for (int c = 0; c < 4000; c++) begin
            soft_reset = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) start = ~start;
            if ($urandom_range(0, 3) == 0) pause = ~pause;
            tick = $urandom_range(0, 1);
            dead[0] = ($urandom_range(0, 9) == 0);
            dead[1] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
